// File: rtl/vending_multi.sv
// Vending-machine controller: 100/500-won coins, N_PROD priced products, cancel,
// and paced change return. Money is counted in 100-won units.
module vending_multi #(
    parameter int                   N_PROD     = 4,
    parameter int                   CW         = 5,
    parameter int                   MAX_CREDIT = 20,
    parameter logic [N_PROD*CW-1:0] PRICES     = {5'd2, 5'd5, 5'd4, 5'd3},
    localparam int                  IW         = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              w100,
    input  logic              w500,
    input  logic [N_PROD-1:0] btn,
    input  logic              cancel,
    output logic              sale,
    output logic [IW-1:0]     sale_id,
    output logic              ret,
    output logic              reject,
    output logic              short,
    output logic              busy,
    output logic [CW-1:0]     credit
);

    typedef enum logic [1:0] {IDLE, HOLD, VEND, CHANGE} state_t;

    state_t          r_state;
    logic            r_sale;
    logic [IW-1:0]   r_sale_id;
    logic            r_ret;
    logic            r_reject;
    logic            r_short;
    logic            r_busy;
    logic [CW-1:0]   r_credit;

    logic            w_btn_any;
    logic [IW-1:0]   w_btn_idx;
    logic [CW-1:0]   w_price;
    logic            w_coin_any;
    logic [CW+1:0]   w_coin_sum;
    logic [CW+1:0]   w_total;
    logic            w_fits;
    logic            w_afford;

    // Lowest set button index wins: scan downward so the last hit is the lowest.
    always_comb begin
        w_btn_idx = '0;
        w_price   = '0;
        for (int i = N_PROD - 1; i >= 0; i--) begin
            if (btn[i]) begin
                w_btn_idx = IW'(i);
                w_price   = PRICES[i*CW +: CW];
            end
        end
    end

    assign w_btn_any  = |btn;
    assign w_coin_any = w100 | w500;
    assign w_coin_sum = {{(CW+1){1'b0}}, w100} + (w500 ? (CW+2)'(5) : (CW+2)'(0));
    assign w_total    = {2'b00, r_credit} + w_coin_sum;
    assign w_fits     = (w_total <= (CW+2)'(MAX_CREDIT));
    assign w_afford   = (r_credit >= w_price);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state   <= IDLE;
            r_sale    <= 1'b0;
            r_sale_id <= '0;
            r_ret     <= 1'b0;
            r_reject  <= 1'b0;
            r_short   <= 1'b0;
            r_busy    <= 1'b0;
            r_credit  <= '0;
        end else begin
            r_sale   <= 1'b0;
            r_ret    <= 1'b0;
            r_reject <= 1'b0;
            r_short  <= 1'b0;
            case (r_state)
                IDLE, HOLD: begin
                    if (cancel && r_state == HOLD) begin
                        r_reject <= w_coin_any;
                        r_state  <= CHANGE;
                        r_busy   <= 1'b1;
                    end else if (w_btn_any) begin
                        r_reject <= w_coin_any;
                        if (w_afford) begin
                            r_sale    <= 1'b1;
                            r_sale_id <= w_btn_idx;
                            r_credit  <= r_credit - w_price;
                            r_state   <= VEND;
                            r_busy    <= 1'b1;
                        end else begin
                            r_short <= 1'b1;
                        end
                    end else if (w_coin_any) begin
                        if (w_fits) begin
                            r_credit <= w_total[CW-1:0];
                            r_state  <= HOLD;
                        end else begin
                            r_reject <= 1'b1;
                        end
                    end
                end
                VEND: begin
                    r_reject <= w_coin_any;
                    if (r_credit != '0) begin
                        r_state <= CHANGE;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                CHANGE: begin
                    // A low cycle follows every ret pulse; leave only after that gap.
                    r_reject <= w_coin_any;
                    if (r_ret) begin
                        if (r_credit == '0) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else if (r_credit != '0) begin
                        r_ret    <= 1'b1;
                        r_credit <= r_credit - CW'(1);
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign sale    = r_sale;
    assign sale_id = r_sale_id;
    assign ret     = r_ret;
    assign reject  = r_reject;
    assign short   = r_short;
    assign busy    = r_busy;
    assign credit  = r_credit;

endmodule

// File: tb/tb_vending_multi.sv
// Self-checking bench for vending_multi: directed scenarios plus random traffic,
// checked each cycle against a queue-based behavioural model of the machine.
module tb_vending_multi;

    localparam int MAXC = 20;

    logic       CLK = 1'b0;
    logic       RSTn = 1'b0;
    logic       w100 = 1'b0;
    logic       w500 = 1'b0;
    logic [3:0] btn = 4'b0000;
    logic       cancel = 1'b0;
    logic       sale;
    logic [1:0] sale_id;
    logic       ret;
    logic       reject;
    logic       short;
    logic       busy;
    logic [4:0] credit;

    vending_multi dut (
        .CLK(CLK), .RSTn(RSTn), .w100(w100), .w500(w500), .btn(btn), .cancel(cancel),
        .sale(sale), .sale_id(sale_id), .ret(ret), .reject(reject), .short(short),
        .busy(busy), .credit(credit)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;
    int PRICE [4] = '{3, 4, 5, 2};

    // Expected outputs for each edge at which the machine is busy.
    typedef struct {
        logic       sale;
        logic [1:0] id;
        logic       ret;
        logic       busy;
        int         cred;
    } ent_t;

    ent_t        m_q[$];
    int          m_credit = 0;
    logic [11:0] exp_vec;

    function automatic ent_t mk(input logic s, input logic [1:0] id, input logic r,
                                input logic b, input int c);
        ent_t e;
        e.sale = s; e.id = id; e.ret = r; e.busy = b; e.cred = c;
        return e;
    endfunction

    function automatic logic [6:0] stim(input logic a, input logic b5,
                                        input logic [3:0] bt, input logic c);
        return {a, b5, bt, c};
    endfunction

    function automatic logic [11:0] obs_vec();
        return {sale, sale ? sale_id : 2'b00, ret, reject, short, busy, credit};
    endfunction

    // k units of change: k pulses, each followed by a low cycle; the last low cycle is idle.
    task automatic payout(input int k);
        for (int j = 1; j <= k; j++) begin
            m_q.push_back(mk(1'b0, 2'd0, 1'b1, 1'b1, k - j));
            m_q.push_back(mk(1'b0, 2'd0, 1'b0, j < k, k - j));
        end
    endtask

    task automatic model(input logic [6:0] s);
        logic a, b5, c, coin, rej, sh;
        logic [3:0] bt;
        int sum, idx, k;
        ent_t e;
        {a, b5, bt, c} = s;
        coin = a | b5;
        sum  = (a ? 1 : 0) + (b5 ? 5 : 0);
        rej  = 1'b0;
        sh   = 1'b0;
        e    = mk(1'b0, 2'd0, 1'b0, 1'b0, m_credit);
        if (m_q.size() != 0) begin
            e   = m_q.pop_front();
            rej = coin;
        end else if (c && m_credit > 0) begin
            rej    = coin;
            e.busy = 1'b1;
            payout(m_credit);
        end else if (bt != 4'b0000) begin
            rej = coin;
            idx = 0;
            while (!bt[idx]) idx++;
            if (m_credit >= PRICE[idx]) begin
                k = m_credit - PRICE[idx];
                e = mk(1'b1, 2'(idx), 1'b0, 1'b1, k);
                m_q.push_back(mk(1'b0, 2'd0, 1'b0, k > 0, k));
                payout(k);
            end else begin
                sh = 1'b1;
            end
        end else if (coin) begin
            if (m_credit + sum <= MAXC) e.cred = m_credit + sum;
            else rej = 1'b1;
        end
        m_credit = e.cred;
        exp_vec  = {e.sale, e.id, e.ret, rej, sh, e.busy, 5'(e.cred)};
    endtask

    task automatic cycle(input logic [6:0] s);
        @(negedge CLK);
        {w100, w500, btn, cancel} = s;
        model(s);
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RSTn = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        vectors++;
        if ({sale, sale_id, ret, reject, short, busy, credit} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset: got %h expected 000", {sale, sale_id, ret, reject, short, busy, credit});
        end
        @(negedge CLK);
        RSTn = 1'b1;
        m_credit = 0;
        m_q.delete();
    endtask

    task automatic test_buy_exact();
        logic [6:0] seq [0:4];
        seq = '{stim(1,0,4'b0000,0), stim(1,0,4'b0000,0), stim(1,0,4'b0000,0),
                stim(0,0,4'b0001,0), stim(0,0,4'b0000,0)};
        foreach (seq[i]) begin
            cycle(seq[i]);
            vectors++;
            if (obs_vec() !== exp_vec) begin
                miscompares++;
                $display("FAIL buy_exact step %0d: got %h expected %h", i, obs_vec(), exp_vec);
            end
        end
        for (int n = 0; n < 60 && m_q.size() > 0; n++) begin
            cycle(7'd0);
            vectors++;
            if (obs_vec() !== exp_vec) begin
                miscompares++;
                $display("FAIL buy_exact drain %0d: got %h expected %h", n, obs_vec(), exp_vec);
            end
        end
        vectors++;
        if (credit !== 5'd0 || busy !== 1'b0 || ret !== 1'b0) begin
            miscompares++;
            $display("FAIL buy_exact end: got credit=%0d busy=%b ret=%b expected 0 0 0", credit, busy, ret);
        end
    endtask

    task automatic test_change_one();
        logic [6:0] seq [0:1];
        seq = '{stim(0,1,4'b0000,0), stim(0,0,4'b0010,0)};
        foreach (seq[i]) begin
            cycle(seq[i]);
            vectors++;
            if (obs_vec() !== exp_vec) begin
                miscompares++;
                $display("FAIL change_one step %0d: got %h expected %h", i, obs_vec(), exp_vec);
            end
        end
        for (int n = 0; n < 60 && m_q.size() > 0; n++) begin
            cycle(7'd0);
            vectors++;
            if (obs_vec() !== exp_vec) begin
                miscompares++;
                $display("FAIL change_one drain %0d: got %h expected %h", n, obs_vec(), exp_vec);
            end
        end
    endtask

    task automatic test_short_cancel();
        logic [6:0] seq [0:4];
        seq = '{stim(1,0,4'b0000,0), stim(1,0,4'b0000,0), stim(0,0,4'b0100,0),
                stim(1,0,4'b0100,0), stim(0,0,4'b0001,1)};
        foreach (seq[i]) begin
            cycle(seq[i]);
            vectors++;
            if (obs_vec() !== exp_vec) begin
                miscompares++;
                $display("FAIL short_cancel step %0d: got %h expected %h", i, obs_vec(), exp_vec);
            end
        end
        for (int n = 0; n < 60 && m_q.size() > 0; n++) begin
            cycle(7'd0);
            vectors++;
            if (obs_vec() !== exp_vec) begin
                miscompares++;
                $display("FAIL short_cancel drain %0d: got %h expected %h", n, obs_vec(), exp_vec);
            end
        end
    endtask

    task automatic test_credit_limit();
        logic [6:0] seq [0:11];
        seq = '{stim(0,1,4'b0000,0), stim(0,1,4'b0000,0), stim(0,1,4'b0000,0),
                stim(1,0,4'b0000,0), stim(1,0,4'b0000,0), stim(1,0,4'b0000,0),
                stim(0,1,4'b0000,0), stim(1,0,4'b0000,0), stim(1,1,4'b0000,0),
                stim(1,0,4'b0000,0), stim(1,0,4'b0000,0), stim(0,0,4'b0000,1)};
        foreach (seq[i]) begin
            cycle(seq[i]);
            vectors++;
            if (obs_vec() !== exp_vec) begin
                miscompares++;
                $display("FAIL credit_limit step %0d: got %h expected %h", i, obs_vec(), exp_vec);
            end
        end
        for (int n = 0; n < 60 && m_q.size() > 0; n++) begin
            cycle(7'd0);
            vectors++;
            if (obs_vec() !== exp_vec) begin
                miscompares++;
                $display("FAIL credit_limit drain %0d: got %h expected %h", n, obs_vec(), exp_vec);
            end
        end
    endtask

    task automatic test_change_reject_and_reset();
        logic [6:0] seq [0:7];
        seq = '{stim(1,0,4'b0000,0), stim(1,0,4'b0000,0), stim(1,0,4'b0000,0),
                stim(0,0,4'b0000,1), stim(0,0,4'b0000,0), stim(1,0,4'b0001,1),
                stim(0,1,4'b0000,0), stim(0,0,4'b0000,0)};
        foreach (seq[i]) begin
            cycle(seq[i]);
            vectors++;
            if (obs_vec() !== exp_vec) begin
                miscompares++;
                $display("FAIL change_reject step %0d: got %h expected %h", i, obs_vec(), exp_vec);
            end
        end
        @(negedge CLK);
        {w100, w500, btn, cancel} = 7'd0;
        #1 RSTn = 1'b0;
        #1;
        vectors++;
        if ({sale, sale_id, ret, reject, short, busy, credit} !== 12'h000) begin
            miscompares++;
            $display("FAIL async_reset: got %h expected 000", {sale, sale_id, ret, reject, short, busy, credit});
        end
        m_q.delete();
        m_credit = 0;
        repeat (2) @(posedge CLK);
        #1;
        vectors++;
        if ({sale, sale_id, ret, reject, short, busy, credit} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_hold: got %h expected 000", {sale, sale_id, ret, reject, short, busy, credit});
        end
        @(negedge CLK);
        RSTn = 1'b1;
        for (int n = 0; n < 4; n++) begin
            cycle(n == 2 ? stim(1,0,4'b0000,0) : stim(0,0,4'b0000,n == 3));
            vectors++;
            if (obs_vec() !== exp_vec) begin
                miscompares++;
                $display("FAIL after_reset step %0d: got %h expected %h", n, obs_vec(), exp_vec);
            end
        end
        for (int n = 0; n < 60 && m_q.size() > 0; n++) begin
            cycle(7'd0);
            vectors++;
            if (obs_vec() !== exp_vec) begin
                miscompares++;
                $display("FAIL after_reset drain %0d: got %h expected %h", n, obs_vec(), exp_vec);
            end
        end
    endtask

    task automatic test_back_to_back();
        cycle(stim(0,1,4'b0000,0));
        cycle(stim(0,1,4'b0000,0));
        for (int n = 0; n < 40; n++) begin
            cycle(stim(n % 7 == 3, 1'b0, 4'b1001, 1'b0));
            vectors++;
            if (obs_vec() !== exp_vec) begin
                miscompares++;
                $display("FAIL back_to_back cycle %0d: got %h expected %h", n, obs_vec(), exp_vec);
            end
        end
        for (int n = 0; n < 60 && m_q.size() > 0; n++) begin
            cycle(7'd0);
            vectors++;
            if (obs_vec() !== exp_vec) begin
                miscompares++;
                $display("FAIL back_to_back drain %0d: got %h expected %h", n, obs_vec(), exp_vec);
            end
        end
    endtask

    task automatic test_random();
        logic a, b5, c;
        logic [3:0] bt;
        for (int n = 0; n < 600; n++) begin
            a  = ($urandom_range(0, 9) < 3);
            b5 = ($urandom_range(0, 9) < 1);
            bt = ($urandom_range(0, 9) < 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
            c  = (m_credit > 0 || m_q.size() > 0) && ($urandom_range(0, 19) == 0);
            cycle(stim(a, b5, bt, c));
            vectors++;
            if (obs_vec() !== exp_vec) begin
                miscompares++;
                $display("FAIL random cycle %0d: got %h expected %h", n, obs_vec(), exp_vec);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_buy_exact();
        test_change_one();
        test_short_cancel();
        test_credit_limit();
        test_change_reject_and_reset();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
